dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (port P) and a loader/DMA requester (port D).
- Sequences each access as a multi-cycle transaction.
- Stalls the pipeline while it is not being served and returns read data to the owning requester.
- Sits between the EX/MEM latch and the data memory.

Parameters:
- MEM_LAT, 2: data memory read latency in cycles, counted from the command cycle to the cycle rdata is valid; legal range 1..15.
- MAX_PIPE_RUN, 4: consecutive P grants allowed while D is waiting; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- p_rd  in  1  MEM-stage memRead
- p_wr  in  1  MEM-stage memWrite
- p_addr  in  32  MEM-stage address
- p_wdata  in  32  MEM-stage write data
- p_rdata  out  32  read data returned to MEM stage
- p_stall  out  1  freeze IF..MEM latches
- d_req  in  1  DMA request
- d_we  in  1  DMA write enable, qualified by d_req
- d_addr  in  32  DMA address
- d_wdata  in  32  DMA write data
- d_rdata  out  32  read data returned to DMA
- d_ack  out  1  one-cycle completion pulse to DMA
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0 at a clock edge), including mid-transaction:
  - state returns to IDLE.
  - mem_read, mem_write, d_ack, busy go to 0.
  - mem_addr, mem_wdata, p_rdata, d_rdata go to 0x0.
  - Any in-flight access is discarded; no ack or data is returned.
- A P request is p_rd|p_wr. If both are set, the access is a write.
- FSM states: IDLE, CMD, WAIT, RESP.
- IDLE:
  - If any request is present, arbitrate and register owner, write flag, address and write data; next state CMD.
  - Otherwise stay in IDLE.
- Arbitration: fixed priority, P over D, unless the optional feature overrides it.
- CMD:
  - Exactly one cycle; mem_read or mem_write is high for that cycle only, with mem_addr/mem_wdata driven from the registered values.
  - Load latency counter with MEM_LAT-1.
  - If MEM_LAT=1, go directly to RESP; otherwise go to WAIT.
- WAIT: decrement the counter; when it reaches 0, go to RESP.
- Read capture: mem_rdata is captured into the owner's rdata register on the edge leaving the final CMD/WAIT cycle. The non-owner's rdata is unchanged. Writes leave both rdata registers unchanged.
- RESP: one cycle, then IDLE.
  - If D owns the transaction, d_ack=1.
  - If P owns it, p_stall drops.
- p_stall is combinational: p_stall = (p_rd|p_wr) & !(state==RESP & owner==P).
  - The pipeline holds the P inputs stable while stalled.
  - The pipeline advances on the RESP edge.
- D holds its inputs until d_ack. Dropping d_req mid-transaction does not abort; d_ack still pulses.
- Latency: request seen in IDLE → completion (RESP) after MEM_LAT+2 cycles. IDLE→IDLE minimum turnaround is MEM_LAT+3 cycles.
- Simultaneous P and D in IDLE: P wins and D waits; D is served on the next IDLE in which P is idle (or forced, see feature).
- Requests arriving during CMD/WAIT/RESP are not sampled until IDLE.
- mem_addr/mem_wdata hold their last values outside CMD.

Optional Feature:
- Macro: DMEM_STARVE_GUARD_EN.
- Defined:
  - A 4-bit run counter increments on each P grant made while d_req=1.
  - The counter clears on any D grant, or on a P grant made with d_req=0.
  - When the count equals MAX_PIPE_RUN and d_req=1 in IDLE, D is granted even if P is requesting.
- Undefined: strict P priority; D can starve indefinitely. No counter logic exists.

Test Plan:
- Reset then idle, MEM_LAT=2: rst=0 for 2 cycles → all outputs 0, busy=0, p_stall=0 with no request.
- P read, p_addr=0x10, memory returns 0xDEADBEEF:
  - mem_read high for exactly 1 cycle with mem_addr=0x10.
  - p_stall high for 3 cycles, then p_rdata=0xDEADBEEF in RESP.
  - d_rdata unchanged.
- D write, d_addr=0x20, d_wdata=0x12345678:
  - mem_write 1 cycle with matching address/data.
  - d_ack single pulse 4 cycles after request.
  - p_rdata and d_rdata unchanged.
- P read and D read raised in the same cycle:
  - P is served first; D's mem_read is issued after P's RESP+IDLE.
  - d_ack follows; D never preempts P.
- Reset asserted during WAIT of a D read:
  - No d_ack, d_rdata=0, state IDLE.
  - A new P request after reset completes normally.
- With DMEM_STARVE_GUARD_EN and MAX_PIPE_RUN=4, P requests continuously and d_req=1:
  - Grant order is P,P,P,P,D,P.
  - Without the macro, D is never granted over 10 transactions.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Single-port data memory arbiter between the MEM stage (P) and a
//            DMA requester (D). Optional starvation guard: DMEM_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MEM_LAT      = 2,
    parameter int MAX_PIPE_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_rd,
    input  logic        p_wr,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    output logic        p_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [3:0] c_lat_init = 4'(MEM_LAT - 1);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
            $error("dmem_arbiter: MEM_LAT must be within 1..15");
        end
        if (MAX_PIPE_RUN < 1 || MAX_PIPE_RUN > 15) begin : g_bad_max_pipe_run
            $error("dmem_arbiter: MAX_PIPE_RUN must be within 1..15");
        end
    endgenerate

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner_d;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_p_rdata;
    logic [31:0] r_d_rdata;
    logic [3:0]  r_cnt;

    logic w_p_req;
    logic w_force_d;
    logic w_grant_p;
    logic w_grant_d;
    logic w_last;

    assign w_p_req   = p_rd | p_wr;
    assign w_grant_d = d_req & (~w_p_req | w_force_d);
    assign w_grant_p = w_p_req & ~w_grant_d;

`ifdef DMEM_STARVE_GUARD_EN
    localparam logic [3:0] c_run_limit = 4'(MAX_PIPE_RUN);
    logic [3:0] r_run;

    // Counts back-to-back P grants that left a waiting D behind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run <= 4'd0;
        end else if (r_state == S_IDLE && w_grant_d) begin
            r_run <= 4'd0;
        end else if (r_state == S_IDLE && w_grant_p) begin
            r_run <= d_req ? (r_run + 4'd1) : 4'd0;
        end
    end

    assign w_force_d = d_req & (r_run == c_run_limit);
`else
    assign w_force_d = 1'b0;
`endif

    // Final cycle of the memory access: read data is valid on this edge.
    assign w_last = ((r_state == S_CMD) && (MEM_LAT == 1)) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_grant_p | w_grant_d) w_state_nxt = S_CMD;
            S_CMD:  w_state_nxt = (MEM_LAT == 1) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 4'd1) w_state_nxt = S_RESP;
            S_RESP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_p_rdata <= 32'h0;
            r_d_rdata <= 32'h0;
            r_cnt     <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_p | w_grant_d) begin
                        r_owner_d <= w_grant_d;
                        r_we      <= w_grant_d ? d_we    : p_wr;
                        r_addr    <= w_grant_d ? d_addr  : p_addr;
                        r_wdata   <= w_grant_d ? d_wdata : p_wdata;
                    end
                end
                S_CMD:   r_cnt <= c_lat_init;
                S_WAIT:  r_cnt <= r_cnt - 4'd1;
                default: ;
            endcase
            if (w_last && !r_we) begin
                if (r_owner_d) r_d_rdata <= mem_rdata;
                else           r_p_rdata <= mem_rdata;
            end
        end
    end

    assign mem_read  = (r_state == S_CMD) & ~r_we;
    assign mem_write = (r_state == S_CMD) &  r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign p_rdata   = r_p_rdata;
    assign d_rdata   = r_d_rdata;
    assign d_ack     = (r_state == S_RESP) & r_owner_d;
    assign busy      = (r_state != S_IDLE);
    // The pipeline is released only in the RESP cycle of its own access.
    assign p_stall   = w_p_req & ~((r_state == S_RESP) & ~r_owner_d);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Vector-table bench for dmem_arbiter (MEM_LAT=2, MAX_PIPE_RUN=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_rd, p_wr;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic        p_stall;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_ack;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.MEM_LAT(2), .MAX_PIPE_RUN(4)) u_dut (
        .clk(clk), .rst(rst),
        .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        prd;
        logic        pwr;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] mrdata;
        logic        e_stall;
        logic        e_mrd;
        logic        e_mwr;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_ack;
        logic        e_busy;
        logic [31:0] e_prd;
        logic [31:0] e_drd;
    } vec_t;

    localparam int NV = 30;
    vec_t v [NV];

    task automatic chk(input int row, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s actual %h required %h", row, name, act, exp);
        end
    endtask

    initial begin
        // rst  prd  pwr  paddr  pwdata  dreq dwe daddr  dwdata  mrdata | stall mrd mwr maddr mwdata ack busy prdata drdata
        v[0]  = '{0,0,0,32'h0,32'h0,0,0,32'h0,32'h0,32'h0,               0,0,0,32'h0,32'h0,0,0,32'h0,32'h0};
        v[1]  = '{1,0,0,32'h0,32'h0,0,0,32'h0,32'h0,32'h0,               0,0,0,32'h0,32'h0,0,0,32'h0,32'h0};
        // P read of 0x10
        v[2]  = '{1,1,0,32'h10,32'h0,0,0,32'h0,32'h0,32'hDEADBEEF,       1,0,0,32'h0,32'h0,0,0,32'h0,32'h0};
        v[3]  = '{1,1,0,32'h10,32'h0,0,0,32'h0,32'h0,32'hDEADBEEF,       1,1,0,32'h10,32'h0,0,1,32'h0,32'h0};
        v[4]  = '{1,1,0,32'h10,32'h0,0,0,32'h0,32'h0,32'hDEADBEEF,       1,0,0,32'h10,32'h0,0,1,32'h0,32'h0};
        v[5]  = '{1,1,0,32'h10,32'h0,0,0,32'h0,32'h0,32'hDEADBEEF,       0,0,0,32'h10,32'h0,0,1,32'hDEADBEEF,32'h0};
        v[6]  = '{1,0,0,32'h0,32'h0,0,0,32'h0,32'h0,32'hDEADBEEF,        0,0,0,32'h10,32'h0,0,0,32'hDEADBEEF,32'h0};
        // D write of 0x12345678 to 0x20
        v[7]  = '{1,0,0,32'h0,32'h0,1,1,32'h20,32'h12345678,32'hCAFEF00D, 0,0,0,32'h10,32'h0,0,0,32'hDEADBEEF,32'h0};
        v[8]  = '{1,0,0,32'h0,32'h0,1,1,32'h20,32'h12345678,32'hCAFEF00D, 0,0,1,32'h20,32'h12345678,0,1,32'hDEADBEEF,32'h0};
        v[9]  = '{1,0,0,32'h0,32'h0,1,1,32'h20,32'h12345678,32'hCAFEF00D, 0,0,0,32'h20,32'h12345678,0,1,32'hDEADBEEF,32'h0};
        v[10] = '{1,0,0,32'h0,32'h0,1,1,32'h20,32'h12345678,32'hCAFEF00D, 0,0,0,32'h20,32'h12345678,1,1,32'hDEADBEEF,32'h0};
        v[11] = '{1,0,0,32'h0,32'h0,0,0,32'h0,32'h0,32'hCAFEF00D,         0,0,0,32'h20,32'h12345678,0,0,32'hDEADBEEF,32'h0};
        // P read 0x30 and D read 0x40 raised together
        v[12] = '{1,1,0,32'h30,32'h0,1,0,32'h40,32'h0,32'h11111111,      1,0,0,32'h20,32'h12345678,0,0,32'hDEADBEEF,32'h0};
        v[13] = '{1,1,0,32'h30,32'h0,1,0,32'h40,32'h0,32'h11111111,      1,1,0,32'h30,32'h0,0,1,32'hDEADBEEF,32'h0};
        v[14] = '{1,1,0,32'h30,32'h0,1,0,32'h40,32'h0,32'h11111111,      1,0,0,32'h30,32'h0,0,1,32'hDEADBEEF,32'h0};
        v[15] = '{1,1,0,32'h30,32'h0,1,0,32'h40,32'h0,32'h11111111,      0,0,0,32'h30,32'h0,0,1,32'h11111111,32'h0};
        v[16] = '{1,0,0,32'h0,32'h0,1,0,32'h40,32'h0,32'h22222222,       0,0,0,32'h30,32'h0,0,0,32'h11111111,32'h0};
        v[17] = '{1,0,0,32'h0,32'h0,1,0,32'h40,32'h0,32'h22222222,       0,1,0,32'h40,32'h0,0,1,32'h11111111,32'h0};
        v[18] = '{1,0,0,32'h0,32'h0,1,0,32'h40,32'h0,32'h22222222,       0,0,0,32'h40,32'h0,0,1,32'h11111111,32'h0};
        v[19] = '{1,0,0,32'h0,32'h0,1,0,32'h40,32'h0,32'h22222222,       0,0,0,32'h40,32'h0,1,1,32'h11111111,32'h22222222};
        v[20] = '{1,0,0,32'h0,32'h0,0,0,32'h0,32'h0,32'h22222222,        0,0,0,32'h40,32'h0,0,0,32'h11111111,32'h22222222};
        // D read of 0x50 killed by reset during WAIT
        v[21] = '{1,0,0,32'h0,32'h0,1,0,32'h50,32'h0,32'h33333333,       0,0,0,32'h40,32'h0,0,0,32'h11111111,32'h22222222};
        v[22] = '{1,0,0,32'h0,32'h0,1,0,32'h50,32'h0,32'h33333333,       0,1,0,32'h50,32'h0,0,1,32'h11111111,32'h22222222};
        v[23] = '{0,0,0,32'h0,32'h0,1,0,32'h50,32'h0,32'h33333333,       0,0,0,32'h50,32'h0,0,1,32'h11111111,32'h22222222};
        v[24] = '{1,0,0,32'h0,32'h0,0,0,32'h0,32'h0,32'h33333333,        0,0,0,32'h0,32'h0,0,0,32'h0,32'h0};
        // P with rd and wr both set behaves as a write
        v[25] = '{1,1,1,32'h60,32'hA5A5A5A5,0,0,32'h0,32'h0,32'h44444444, 1,0,0,32'h0,32'h0,0,0,32'h0,32'h0};
        v[26] = '{1,1,1,32'h60,32'hA5A5A5A5,0,0,32'h0,32'h0,32'h44444444, 1,0,1,32'h60,32'hA5A5A5A5,0,1,32'h0,32'h0};
        v[27] = '{1,1,1,32'h60,32'hA5A5A5A5,0,0,32'h0,32'h0,32'h44444444, 1,0,0,32'h60,32'hA5A5A5A5,0,1,32'h0,32'h0};
        v[28] = '{1,1,1,32'h60,32'hA5A5A5A5,0,0,32'h0,32'h0,32'h44444444, 0,0,0,32'h60,32'hA5A5A5A5,0,1,32'h0,32'h0};
        v[29] = '{1,0,0,32'h0,32'h0,0,0,32'h0,32'h0,32'h44444444,         0,0,0,32'h60,32'hA5A5A5A5,0,0,32'h0,32'h0};

        rst = 1'b0; p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = v[i].rst; p_rd = v[i].prd; p_wr = v[i].pwr;
            p_addr = v[i].paddr; p_wdata = v[i].pwdata;
            d_req = v[i].dreq; d_we = v[i].dwe;
            d_addr = v[i].daddr; d_wdata = v[i].dwdata;
            mem_rdata = v[i].mrdata;
            #1;
            chk(i, "p_stall",   32'(p_stall),   32'(v[i].e_stall));
            chk(i, "mem_read",  32'(mem_read),  32'(v[i].e_mrd));
            chk(i, "mem_write", 32'(mem_write), 32'(v[i].e_mwr));
            chk(i, "mem_addr",  mem_addr,       v[i].e_maddr);
            chk(i, "mem_wdata", mem_wdata,      v[i].e_mwdata);
            chk(i, "d_ack",     32'(d_ack),     32'(v[i].e_ack));
            chk(i, "busy",      32'(busy),      32'(v[i].e_busy));
            chk(i, "p_rdata",   p_rdata,        v[i].e_prd);
            chk(i, "d_rdata",   d_rdata,        v[i].e_drd);
        end

        // Continuous P reads of 0x70 against a permanently waiting D at 0x80.
        begin
            int n_grants;
            logic [31:0] exp_addr;
            n_grants = 0;
            @(negedge clk);
            p_rd = 1'b1; p_wr = 1'b0; p_addr = 32'h70;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
            mem_rdata = 32'h55555555;
            for (int cyc = 0; cyc < 100 && n_grants < 10; cyc++) begin
                @(negedge clk);
                #1;
                if (mem_read) begin
`ifdef DMEM_STARVE_GUARD_EN
                    exp_addr = (n_grants == 4 || n_grants == 9) ? 32'h80 : 32'h70;
`else
                    exp_addr = 32'h70;
`endif
                    chk(100 + n_grants, "grant_addr", mem_addr, exp_addr);
                    n_grants++;
                end
            end
            chk(200, "grant_count", 32'(n_grants), 32'd10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
